// File: rtl/ecall_handler.sv
// ecall_handler: services PRINT_INT / READ_INT environment calls.
// The pipeline stalls until a debounced confirm press completes the call.
module ecall_handler #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eRead,
  input  logic                eWrite,
  input  logic [11:0]         EcallOp,
  input  logic [31:0]         a0_in,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                confirm_btn,
  output logic                stall,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  output logic [31:0]         disp_data,
  output logic [11:0]         cur_op,
  output logic                wait_led
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_db_level;
  logic [CW-1:0]   r_db_cnt;
  logic            r_press;
  logic            r_mode;
  logic [11:0]     r_cur_op;
  logic [31:0]     r_disp;
  logic [31:0]     r_rd_data;
  logic            w_req;
  logic            w_accept;
  logic            w_complete;
  logic [31:0]     w_sw_ext;

  assign w_req     = eRead | eWrite;
  assign w_sw_ext  = 32'($signed(sw));
  assign rd_data   = r_rd_data;
  assign disp_data = r_disp;
  assign cur_op    = r_cur_op;

  // Button path: synchronize, debounce, and emit a one-cycle rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= confirm_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_MAX) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
        r_press    <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and combinational outputs; stall covers the first decode cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    stall       = 1'b0;
    rd_valid    = 1'b0;
    wait_led    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall    = 1'b1;
        wait_led = 1'b1;
        if (r_press) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rd_valid    = r_mode;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latching, display load and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= 1'b0;
      r_cur_op  <= '0;
      r_disp    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_mode   <= eRead;
        r_cur_op <= EcallOp;
        if (!eRead) begin
          r_disp <= a0_in;
        end
      end
      if (w_complete && r_mode) begin
        r_rd_data <= w_sw_ext;
      end
      if (r_state == S_DONE) begin
        r_cur_op <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ecall_handler.sv
// tb_ecall_handler: vector table, corner sequences and randomized
// transactions checked against a transaction-level model.
module tb_ecall_handler;

  localparam int DC = 4;
  localparam int SWW = 16;
  localparam int PRESS_LAT = 2 + DC + 1;

  logic           clk;
  logic           rst;
  logic           eRead;
  logic           eWrite;
  logic [11:0]    EcallOp;
  logic [31:0]    a0_in;
  logic [SWW-1:0] sw;
  logic           confirm_btn;
  logic           stall;
  logic [31:0]    rd_data;
  logic           rd_valid;
  logic [31:0]    disp_data;
  logic [11:0]    cur_op;
  logic           wait_led;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_disp;
  logic [31:0] m_rd;

  typedef struct {
    bit          rd;
    logic [11:0] op;
    logic [31:0] a0;
    logic [15:0] swv;
    int          dly;
    logic [31:0] exp_disp;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  ecall_handler #(
    .DEBOUNCE_CYCLES(DC),
    .SW_WIDTH(SWW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eRead(eRead),
    .eWrite(eWrite),
    .EcallOp(EcallOp),
    .a0_in(a0_in),
    .sw(sw),
    .confirm_btn(confirm_btn),
    .stall(stall),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .disp_data(disp_data),
    .cur_op(cur_op),
    .wait_led(wait_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    return s;
  endfunction

  task automatic accept_txn(input bit rd, input logic [11:0] op,
                            input logic [31:0] a0, input logic [15:0] swv,
                            input logic [31:0] exp_disp);
    eRead = rd;
    eWrite = !rd;
    EcallOp = op;
    a0_in = a0;
    sw = swv;
    #1;
    chk("stall_first_cycle", stall, 1);
    chk("wait_led_idle", wait_led, 0);
    tick();
    chk("wait_led_wait", wait_led, 1);
    chk("stall_wait_entry", stall, 1);
    chk("cur_op_wait", cur_op, op);
    chk("disp_after_accept", disp_data, exp_disp);
  endtask

  task automatic finish_txn(input bit rd, input logic [11:0] op,
                            input logic [31:0] exp_disp,
                            input logic [31:0] exp_rd);
    int lat;
    bit done;
    confirm_btn = 1'b1;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (stall === 1'b0) done = 1'b1;
      else chk("rd_valid_while_wait", rd_valid, 0);
    end
    chk("press_latency", lat, PRESS_LAT);
    chk("rd_valid_done", rd_valid, rd);
    chk("cur_op_done", cur_op, op);
    chk("wait_led_done", wait_led, 0);
    if (rd) chk("rd_data_done", rd_data, exp_rd);
    tick();
    eRead = 1'b0;
    eWrite = 1'b0;
    #1;
    chk("stall_after_done", stall, 0);
    chk("rd_valid_after_done", rd_valid, 0);
    chk("cur_op_after_done", cur_op, 0);
    chk("rd_data_hold", rd_data, exp_rd);
    chk("disp_hold", disp_data, exp_disp);
    confirm_btn = 1'b0;
    repeat (8) begin
      tick();
      chk("stall_idle", stall, 0);
      chk("rd_valid_idle", rd_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    eRead = 1'b0;
    eWrite = 1'b0;
    EcallOp = '0;
    a0_in = '0;
    sw = '0;
    confirm_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_disp", disp_data, 0);
    chk("reset_cur_op", cur_op, 0);
    chk("reset_wait_led", wait_led, 0);
    tick();

    tbl[0] = '{1'b0, 12'd1, 32'h0000002A, 16'h0000, 10,
               32'h0000002A, 32'h00000000};
    tbl[1] = '{1'b1, 12'd5, 32'h00000077, 16'hFFF6, 3,
               32'h0000002A, 32'hFFFFFFF6};
    tbl[2] = '{1'b1, 12'd5, 32'h00000000, 16'h7FFF, 0,
               32'h0000002A, 32'h00007FFF};
    tbl[3] = '{1'b0, 12'd1, 32'hDEADBEEF, 16'h1234, 1,
               32'hDEADBEEF, 32'h00007FFF};
    tbl[4] = '{1'b1, 12'hABC, 32'h00000000, 16'h8000, 2,
               32'hDEADBEEF, 32'hFFFF8000};
    tbl[5] = '{1'b1, 12'h005, 32'h00000000, 16'h0001, 0,
               32'hDEADBEEF, 32'h00000001};

    for (int i = 0; i < 6; i++) begin
      accept_txn(tbl[i].rd, tbl[i].op, tbl[i].a0, tbl[i].swv,
                 tbl[i].exp_disp);
      repeat (tbl[i].dly) begin
        tick();
        chk("stall_hold", stall, 1);
        chk("rd_valid_hold", rd_valid, 0);
      end
      finish_txn(tbl[i].rd, tbl[i].op, tbl[i].exp_disp, tbl[i].exp_rd);
    end
    m_disp = 32'hDEADBEEF;
    m_rd = 32'h00000001;

    // Bouncing button never completes the call.
    accept_txn(1'b1, 12'd7, 32'h0, 16'h0042, m_disp);
    for (int i = 0; i < 5; i++) begin
      confirm_btn = 1'b1;
      repeat (2) begin
        tick();
        chk("bounce_stall", stall, 1);
        chk("bounce_wait_led", wait_led, 1);
      end
      confirm_btn = 1'b0;
      repeat (2) begin
        tick();
        chk("bounce_stall", stall, 1);
        chk("bounce_rd_valid", rd_valid, 0);
      end
    end
    repeat (8) begin
      tick();
      chk("bounce_settle_stall", stall, 1);
    end
    m_rd = 32'h00000042;
    finish_txn(1'b1, 12'd7, m_disp, m_rd);

    // Button already held at accept needs release and a fresh press.
    confirm_btn = 1'b1;
    repeat (10) tick();
    accept_txn(1'b1, 12'd3, 32'h0, 16'h00AB, m_disp);
    repeat (10) begin
      tick();
      chk("held_stall", stall, 1);
      chk("held_rd_valid", rd_valid, 0);
    end
    confirm_btn = 1'b0;
    repeat (8) begin
      tick();
      chk("held_release_stall", stall, 1);
    end
    m_rd = 32'h000000AB;
    finish_txn(1'b1, 12'd3, m_disp, m_rd);

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      bit rd;
      logic [11:0] op;
      logic [31:0] a0;
      logic [15:0] swv;
      int dly;
      if ($urandom_range(0, 3) == 0) begin
        confirm_btn = 1'b1;
        repeat (8) begin
          tick();
          chk("idle_press_stall", stall, 0);
          chk("idle_press_wait_led", wait_led, 0);
        end
        confirm_btn = 1'b0;
        repeat (8) begin
          tick();
          chk("idle_release_stall", stall, 0);
        end
      end
      rd = 1'($urandom_range(0, 1));
      op = 12'($urandom);
      a0 = $urandom;
      swv = 16'($urandom);
      dly = $urandom_range(0, 6);
      if (rd) m_rd = sext16(swv);
      else m_disp = a0;
      accept_txn(rd, op, a0, swv, m_disp);
      repeat (dly) begin
        tick();
        chk("rand_stall_hold", stall, 1);
      end
      finish_txn(rd, op, m_disp, m_rd);
    end

    // Asynchronous reset in the middle of a pending read.
    m_disp = 32'h00000055;
    accept_txn(1'b0, 12'd1, m_disp, 16'h0, m_disp);
    finish_txn(1'b0, 12'd1, m_disp, m_rd);
    accept_txn(1'b1, 12'd5, 32'h0, 16'h1111, m_disp);
    tick();
    eRead = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_stall", stall, 0);
    chk("rst_async_rd_valid", rd_valid, 0);
    chk("rst_async_disp", disp_data, 0);
    chk("rst_async_wait_led", wait_led, 0);
    chk("rst_async_cur_op", cur_op, 0);
    chk("rst_async_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("post_rst_stall", stall, 0);
      chk("post_rst_rd_valid", rd_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecall_handler.md
# ecall_handler

Services the environment calls raised by the pipeline's decode stage: PRINT_INT shows a0 on the board display, READ_INT returns the switch value for a0. Sits between the decoder's eRead/eWrite/EcallOp outputs and the board I/O (switches, confirm button, 7-seg/LED driver). Freezes the pipeline with `stall` until the user presses the confirm button. Returns read data to the register-file write port.

## Interface
- DEBOUNCE_CYCLES, 200000: number of consecutive stable cycles before the synchronized button level is accepted (use 4 in simulation).
- SW_WIDTH, 16: number of switch inputs.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- eRead  in  1  decoder requests READ_INT.
- eWrite  in  1  decoder requests PRINT_INT.
- EcallOp  in  12  decoder ecall code; latched at accept.
- a0_in  in  32  current a0 value, used for print.
- sw  in  SW_WIDTH  raw switch levels; sampled at confirm.
- confirm_btn  in  1  raw, asynchronous push-button.
- stall  out  1  freeze PC and the IF/ID register while high.
- rd_data  out  32  sign-extended switch value for a0.
- rd_valid  out  1  one-cycle pulse; write rd_data to a0.
- disp_data  out  32  last printed value; held until the next print.
- cur_op  out  12  EcallOp latched at accept; 0 when idle.
- wait_led  out  1  high while waiting for confirm.

## Operation
- Button path:
  - Two-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized level differs from the debounced level.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value.
  - `press` is a one-cycle pulse on a 0→1 edge of the debounced level. A button held across an accept produces no press.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Accept occurs when eRead | eWrite.
  - On accept: latch EcallOp into cur_op and the kind of request (read/print) into a mode bit. eRead has priority if both are high.
  - Print accept: load disp_data <= a0_in on the same edge.
  - Next state is WAIT.
- WAIT:
  - On press: if mode is read, rd_data <= sign-extend(sw) to 32 bits. Next state is DONE.
  - Without press: stay in WAIT.
- DONE:
  - rd_valid = 1 for one cycle, only if mode is read.
  - eRead/eWrite are ignored, because the stalled ecall is still in decode this cycle.
  - Next state is IDLE; cur_op <= 0.
- stall = (IDLE & (eRead | eWrite)) | WAIT. This is combinational in IDLE, so the ecall freezes in its first decode cycle. stall is low in DONE.
- wait_led = (state == WAIT).
- rd_data holds its value after DONE. rd_valid gates its use.
- A press while in IDLE or DONE is discarded; it is not queued.

## Timing
- Reset values:
  - state = IDLE
  - stall = 0 when eRead/eWrite are low
  - rd_data = 0, rd_valid = 0
  - disp_data = 0, cur_op = 0, wait_led = 0
  - debounced level = 0, debounce counter = 0, synchronizer flops = 0
- Reset asserted mid-WAIT: all state clears immediately (asynchronous). A pending read returns nothing.
- Accept at edge t (request present in cycle t-1, stall already high in t-1). WAIT from t.
- Press latency: raw button rise → press pulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
- Press in cycle p: DONE in cycle p+1, with stall = 0 and rd_valid = 1. The pipeline advances at the end of p+1. IDLE in p+2.
- Back-to-back ecalls: the second is accepted in IDLE at p+2 at the earliest, and requires a new press.
- Debounce glitch: an input bounce shorter than DEBOUNCE_CYCLES stable cycles produces no press.

## Test plan
- Print:
  - Stimulus: eWrite=1, EcallOp=1, a0_in=0x0000002A; confirm pulse after 10 cycles.
  - Required: stall high from the first cycle; disp_data=0x2A one edge later; wait_led high; stall low exactly 2+4+1 cycles after the button rise (DEBOUNCE_CYCLES=4); rd_valid never high.
- Read negative:
  - Stimulus: sw=0xFFF6, eRead=1, EcallOp=5; confirm pressed.
  - Required: single rd_valid pulse with rd_data=0xFFFFFFF6, coincident with stall=0; cur_op=5 during WAIT, 0 after DONE.
- Bounce:
  - Stimulus: confirm toggles 1/0 every 2 cycles for 20 cycles, then stays 0.
  - Required: no press, state stays WAIT, stall stays 1.
- Held button:
  - Stimulus: button held high before accept.
  - Required: no completion until the button is released (stable) and pressed again.
- Reset mid-wait:
  - Stimulus: assert rst in WAIT, then eRead=0.
  - Required: stall=0, rd_valid=0, disp_data=0, wait_led=0 immediately, without waiting for a clock edge.
- DONE re-trigger guard:
  - Stimulus: eRead held high through DONE, then dropped at p+2.
  - Required: exactly one rd_valid pulse and no second accept.
